// File: rtl/ofmap_writeback_ctrl.sv
// Output feature-map write-back: quantises each finished accumulator lane and
// writes it into its output-map bank, flagging completion and dropped results.
module ofmap_writeback_ctrl #(
  parameter int DATA_WIDTH        = 16,
  parameter int ACC_WIDTH         = 32,
  parameter int NUM_DSP           = 2,
  parameter int NUM_ONEMULT       = 2,
  parameter int OUT_FEATURE_WIDTH = 3,
  parameter int FRAC_SHIFT        = 8,
  parameter int RELU              = 1,
  parameter int NUM_OUT_MEM       = NUM_DSP * NUM_ONEMULT,
  parameter int ADDR_WIDTH        = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         result_valid,
  input  logic [ACC_WIDTH*NUM_DSP-1:0] result_all,
  output logic [NUM_OUT_MEM-1:0]       out_wren,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         busy,
  output logic                         wb_done,
  output logic                         overflow,
  output logic [1:0]                   dbg_state
);

  localparam int PIX_TOTAL = OUT_FEATURE_WIDTH * OUT_FEATURE_WIDTH;
  localparam int LANE_W    = (NUM_DSP > 1) ? $clog2(NUM_DSP) : 1;
  localparam int GRP_W     = (NUM_ONEMULT > 1) ? $clog2(NUM_ONEMULT) : 1;

  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(NUM_DSP - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX  = ADDR_WIDTH'(PIX_TOTAL - 1);
  localparam logic [GRP_W-1:0]      LAST_GRP  = GRP_W'(NUM_ONEMULT - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2**(DATA_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ACC_WIDTH*NUM_DSP-1:0] hold_reg;
  logic [LANE_W-1:0]            lane_cnt;
  logic [ADDR_WIDTH-1:0]        pix_cnt;
  logic [GRP_W-1:0]             grp_cnt;

  logic                         last_lane, last_pix, last_grp;
  logic [ACC_WIDTH-1:0]         lane_val;
  logic signed [ACC_WIDTH-1:0]  shifted, quant;
  logic [NUM_OUT_MEM-1:0]       wren_nxt;

  assign last_lane = (lane_cnt == LAST_LANE);
  assign last_pix  = (pix_cnt == LAST_PIX);
  assign last_grp  = (grp_cnt == LAST_GRP);

  assign busy      = (state == S_WRITE);
  assign dbg_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (result_valid) state_nxt = S_WRITE;
        S_WRITE: if (last_lane) state_nxt = (last_pix && last_grp) ? S_DONE : S_IDLE;
        S_DONE:  state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    lane_val = '0;
    for (int k = 0; k < NUM_DSP; k++) begin
      if (int'(lane_cnt) == k) lane_val = hold_reg[k*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  // Shift at full accumulator width first so saturation sees the true magnitude.
  always_comb begin
    shifted = $signed(lane_val) >>> FRAC_SHIFT;
    quant   = shifted;
    if (RELU != 0 && quant[ACC_WIDTH-1]) quant = '0;
    if (quant > SAT_MAX)      quant = SAT_MAX;
    else if (quant < SAT_MIN) quant = SAT_MIN;
  end

  assign wren_nxt = NUM_OUT_MEM'(1) << (int'(grp_cnt) * NUM_DSP + int'(lane_cnt));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_reg <= '0;
      lane_cnt <= '0;
      pix_cnt  <= '0;
      grp_cnt  <= '0;
      out_wren <= '0;
      out_addr <= '0;
      out_data <= '0;
      wb_done  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      out_wren <= '0;
      out_addr <= '0;
      out_data <= '0;
      if (clear) begin
        lane_cnt <= '0;
        pix_cnt  <= '0;
        grp_cnt  <= '0;
        wb_done  <= 1'b0;
        overflow <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (result_valid) begin
              hold_reg <= result_all;
              lane_cnt <= '0;
            end
          end
          S_WRITE: begin
            out_wren <= wren_nxt;
            out_addr <= pix_cnt;
            out_data <= quant[DATA_WIDTH-1:0];
            if (result_valid) overflow <= 1'b1;
            if (last_lane) begin
              lane_cnt <= '0;
              if (last_pix) begin
                pix_cnt <= '0;
                grp_cnt <= last_grp ? '0 : grp_cnt + GRP_W'(1);
              end else begin
                pix_cnt <= pix_cnt + ADDR_WIDTH'(1);
              end
            end else begin
              lane_cnt <= lane_cnt + LANE_W'(1);
            end
          end
          S_DONE: begin
            wb_done <= 1'b1;
            if (result_valid) overflow <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ofmap_writeback_ctrl.sv
// Bench for ofmap_writeback_ctrl: scoreboarded bank writes plus targeted
// timing, quantisation, overflow, clear and reset scenarios.
module tb_ofmap_writeback_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear = 1'b0;
  logic        result_valid = 1'b0;
  logic [63:0] result_all = '0;

  logic [3:0]  out_wren, out_wren2;
  logic [3:0]  out_addr, out_addr2;
  logic [15:0] out_data, out_data2;
  logic        busy, wb_done, overflow, busy2, wb_done2, overflow2;
  logic [1:0]  dbg_state, dbg_state2;

  int          checks = 0;
  int          failures = 0;
  logic [23:0] exp_q[$];
  int          m_pix = 0;
  int          m_grp = 0;

  always #5 clock = ~clock;

  ofmap_writeback_ctrl dut (
    .clock(clock), .reset(reset), .clear(clear),
    .result_valid(result_valid), .result_all(result_all),
    .out_wren(out_wren), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .wb_done(wb_done), .overflow(overflow), .dbg_state(dbg_state)
  );

  ofmap_writeback_ctrl #(.RELU(0)) dut_norelu (
    .clock(clock), .reset(reset), .clear(clear),
    .result_valid(result_valid), .result_all(result_all),
    .out_wren(out_wren2), .out_addr(out_addr2), .out_data(out_data2),
    .busy(busy2), .wb_done(wb_done2), .overflow(overflow2), .dbg_state(dbg_state2)
  );

  function automatic logic [15:0] q_model(input logic [31:0] x, input bit relu);
    longint v;
    v = longint'($signed(x)) >>> 8;
    if (relu && v < 0) v = 0;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic push_lane(input logic [31:0] v, input int lane);
    exp_q.push_back({4'(1 << (m_grp * 2 + lane)), 4'(m_pix), q_model(v, 1'b1)});
  endtask

  task automatic advance_model();
    m_pix++;
    if (m_pix == 9) begin
      m_pix = 0;
      m_grp = (m_grp == 1) ? 0 : m_grp + 1;
    end
  endtask

  // Caller sits at a negedge; returns `period` negedges later.
  task automatic send_pixel(input logic [31:0] l0, input logic [31:0] l1,
                            input int period, input bit accept);
    result_all   = {l1, l0};
    result_valid = 1'b1;
    if (accept) begin
      push_lane(l0, 0);
      push_lane(l1, 1);
      advance_model();
    end
    @(negedge clock);
    result_valid = 1'b0;
    repeat (period - 1) @(negedge clock);
  endtask

  function automatic logic [31:0] rand_lane();
    return $urandom_range(0, 32'h00FF_FFFF) - 32'h0080_0000;
  endfunction

  task automatic test_reset_state();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({out_wren, out_addr, out_data, busy, wb_done, overflow, dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset_state got wren=%b addr=%h data=%h busy=%b done=%b ovf=%b st=%0d expected all zero",
               out_wren, out_addr, out_data, busy, wb_done, overflow, dbg_state);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_pixel();
    result_all   = {32'h0000_0300, 32'h0000_0500};
    result_valid = 1'b1;
    push_lane(32'h0000_0500, 0);
    push_lane(32'h0000_0300, 1);
    advance_model();
    @(negedge clock);
    result_valid = 1'b0;
    checks++;
    if ({busy, out_wren} !== 5'b1_0000) begin
      failures++;
      $display("FAIL single_cycle1 got busy=%b wren=%b expected busy=1 wren=0000", busy, out_wren);
    end
    @(negedge clock);
    checks++;
    if ({busy, out_wren, out_addr, out_data} !== {1'b1, 4'b0001, 4'd0, 16'h0005}) begin
      failures++;
      $display("FAIL single_lane0 got busy=%b wren=%b addr=%0d data=%h expected 1/0001/0/0005",
               busy, out_wren, out_addr, out_data);
    end
    @(negedge clock);
    checks++;
    if ({busy, out_wren, out_addr, out_data} !== {1'b0, 4'b0010, 4'd0, 16'h0003}) begin
      failures++;
      $display("FAIL single_lane1 got busy=%b wren=%b addr=%0d data=%h expected 0/0010/0/0003",
               busy, out_wren, out_addr, out_data);
    end
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0 || out_wren !== 4'b0) begin
      failures++;
      $display("FAIL single_drain got pending=%0d wren=%b expected 0/0000", exp_q.size(), out_wren);
    end
  endtask

  task automatic test_quant();
    logic [31:0] lo [2];
    logic [31:0] hi [2];
    lo[0] = 32'hFFFF_F000; hi[0] = 32'h7FFF_FFFF;
    lo[1] = 32'h8000_0000; hi[1] = 32'h0123_4567;
    for (int i = 0; i < 2; i++) begin
      result_all   = {hi[i], lo[i]};
      result_valid = 1'b1;
      push_lane(lo[i], 0);
      push_lane(hi[i], 1);
      advance_model();
      @(negedge clock);
      result_valid = 1'b0;
      @(negedge clock);
      checks++;
      if ({out_data, out_data2} !== {q_model(lo[i], 1'b1), q_model(lo[i], 1'b0)}) begin
        failures++;
        $display("FAIL quant_lane0_%0d got relu=%h norelu=%h expected %h %h", i,
                 out_data, out_data2, q_model(lo[i], 1'b1), q_model(lo[i], 1'b0));
      end
      @(negedge clock);
      checks++;
      if ({out_data, out_data2} !== {q_model(hi[i], 1'b1), q_model(hi[i], 1'b0)}) begin
        failures++;
        $display("FAIL quant_lane1_%0d got relu=%h norelu=%h expected %h %h", i,
                 out_data, out_data2, q_model(hi[i], 1'b1), q_model(hi[i], 1'b0));
      end
    end
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL quant_drain got pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [31:0] a, b;
    a = rand_lane();
    b = rand_lane();
    result_all   = {b, a};
    result_valid = 1'b1;
    push_lane(a, 0);
    push_lane(b, 1);
    advance_model();
    @(negedge clock);
    result_all = ~{b, a};
    @(negedge clock);
    result_valid = 1'b0;
    #1;
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_rise got %b expected 1", overflow);
    end
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0 || overflow !== 1'b1 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL overflow_after got pending=%0d ovf=%b st=%0d expected 0/1/0",
               exp_q.size(), overflow, dbg_state);
    end
  endtask

  task automatic test_clear_same_cycle();
    clear        = 1'b1;
    result_valid = 1'b1;
    result_all   = {rand_lane(), rand_lane()};
    @(negedge clock);
    clear        = 1'b0;
    result_valid = 1'b0;
    m_pix = 0;
    m_grp = 0;
    checks++;
    if ({overflow, dbg_state, out_wren} !== 7'b0) begin
      failures++;
      $display("FAIL clear_same_cycle got ovf=%b st=%0d wren=%b expected 0/0/0000",
               overflow, dbg_state, out_wren);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0 || out_wren !== 4'b0) begin
      failures++;
      $display("FAIL clear_no_write got pending=%0d wren=%b expected 0/0000", exp_q.size(), out_wren);
    end
  endtask

  task automatic test_full_layer();
    for (int i = 0; i < 17; i++) send_pixel(rand_lane(), rand_lane(), 4, 1'b1);
    send_pixel(rand_lane(), rand_lane(), 3, 1'b1);
    #1;
    checks++;
    if ({wb_done, dbg_state} !== {1'b0, 2'd2}) begin
      failures++;
      $display("FAIL layer_last_write got done=%b st=%0d expected 0/2", wb_done, dbg_state);
    end
    @(negedge clock);
    #1;
    checks++;
    if ({wb_done, overflow, out_wren} !== {1'b1, 1'b0, 4'b0} || exp_q.size() != 0) begin
      failures++;
      $display("FAIL layer_done got done=%b ovf=%b wren=%b pending=%0d expected 1/0/0000/0",
               wb_done, overflow, out_wren, exp_q.size());
    end
  endtask

  task automatic test_clear_done();
    send_pixel(rand_lane(), rand_lane(), 3, 1'b0);
    #1;
    checks++;
    if ({wb_done, overflow, dbg_state} !== {1'b1, 1'b1, 2'd2}) begin
      failures++;
      $display("FAIL done_drop got done=%b ovf=%b st=%0d expected 1/1/2", wb_done, overflow, dbg_state);
    end
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    m_pix = 0;
    m_grp = 0;
    #1;
    checks++;
    if ({wb_done, overflow, dbg_state} !== 4'b0) begin
      failures++;
      $display("FAIL clear_done got done=%b ovf=%b st=%0d expected 0/0/0", wb_done, overflow, dbg_state);
    end
    send_pixel(32'h0000_0A00, 32'h0000_0100, 3, 1'b1);
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL clear_restart got pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] a;
    a = rand_lane();
    result_all   = {rand_lane(), a};
    result_valid = 1'b1;
    push_lane(a, 0);
    @(negedge clock);
    result_valid = 1'b0;
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({out_wren, out_addr, out_data, busy, wb_done, overflow, dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset_async got wren=%b addr=%h data=%h busy=%b st=%0d expected all zero",
               out_wren, out_addr, out_data, busy, dbg_state);
    end
    @(negedge clock);
    reset = 1'b0;
    m_pix = 0;
    m_grp = 0;
    repeat (2) @(negedge clock);
    checks++;
    if (exp_q.size() != 0 || out_wren !== 4'b0) begin
      failures++;
      $display("FAIL reset_no_finish got pending=%0d wren=%b expected 0/0000", exp_q.size(), out_wren);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] exp;
    reset = 1'b0;
    #1;
    fork
      forever begin
        @(negedge clock);
        if (out_wren !== 4'b0) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL write_unexpected got wren=%b addr=%0d data=%h expected no write",
                     out_wren, out_addr, out_data);
          end else begin
            exp = exp_q.pop_front();
            if ({out_wren, out_addr, out_data} !== exp) begin
              failures++;
              $display("FAIL write_scoreboard got wren=%b addr=%0d data=%h expected wren=%b addr=%0d data=%h",
                       out_wren, out_addr, out_data, exp[23:20], exp[19:16], exp[15:0]);
            end
          end
        end
      end
    join_none
    test_reset_state();
    test_single_pixel();
    test_quant();
    test_overflow();
    test_clear_same_cycle();
    test_full_layer();
    test_clear_done();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
